// File: rtl/spi_dac_pkg.sv
// Shared types and word formatting for the spi_dac_stream MCP4922-class DAC driver.
// The optional per-channel gain select is enabled with SPI_DAC_GAIN_SEL_EN (see spi_dac_stream).
package spi_dac_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SHIFT = 3'd1,
      GAP   = 3'd2,
      LDAC  = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int WORD_W     = 16;
   localparam int CFG_AB     = 15;
   localparam int CFG_BUF    = 14;
   localparam int CFG_GA_N   = 13;
   localparam int CFG_SHDN_N = 12;

   // Only the channel parity matters: even channels go to DAC A, odd to DAC B.
   function automatic logic [WORD_W-1:0] build_word(input logic [7:0]  ch,
                                                    input logic [11:0] sample,
                                                    input logic        ga_n);
      logic [WORD_W-1:0] w;
      w             = {4'b0000, sample};
      w[CFG_AB]     = ch[0];
      w[CFG_BUF]    = 1'b0;
      w[CFG_GA_N]   = ga_n;
      w[CFG_SHDN_N] = 1'b1;
      return w;
   endfunction

endpackage

// File: rtl/spi_dac_clkdiv.sv
// Tick generator for the SPI half-period: one-cycle tick every CLK_DIV clocks.
// A synchronous clear restarts the count so a frame always begins on a full half-period.
module spi_dac_clkdiv #(
   parameter int CLK_DIV = 25
) (
   input  logic clk,
   input  logic clr,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (clr || tick) cnt <= '0;
      else             cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/spi_dac_stream.sv
// Frame-based SPI master for MCP4922-class dual DACs: one 16-bit word per channel, then one LDAC_n strobe.
// Define SPI_DAC_GAIN_SEL_EN to add the s_gain1x port; otherwise every channel runs at 1x gain.
module spi_dac_stream
   import spi_dac_pkg::*;
#(
   parameter int CLK_DIV = 25,
   parameter int N_CH    = 2,
   parameter int DATA_W  = 12,
   parameter int CS_GAP  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [N_CH*DATA_W-1:0] s_data,
`ifdef SPI_DAC_GAIN_SEL_EN
   input  logic [N_CH-1:0]        s_gain1x,
`endif
   output logic                   sck,
   output logic                   sdi,
   output logic [N_CH/2-1:0]      cs_n,
   output logic                   ldac_n,
   output logic                   busy,
   output logic                   frame_done
);

   localparam int CH_W = $clog2(N_CH);
   localparam int GW   = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

   state_t                   state;
   logic                     phase;
   logic [3:0]               bit_cnt;
   logic [GW-1:0]            gap_cnt;
   logic [CH_W-1:0]          ch;
   logic [CH_W-1:0]          nxt_ch;
   logic [WORD_W-1:0]        sr;
   logic [N_CH*DATA_W-1:0]   frame_buf;
   logic [N_CH-1:0]          ga_buf;
   logic [N_CH-1:0]          ga_in;
   logic                     accept;
   logic                     tick;
   logic                     period_end;
   logic                     gap_last;
   logic                     ch_last;
   logic [WORD_W-1:0]        first_word;
   logic [WORD_W-1:0]        next_word;

`ifdef SPI_DAC_GAIN_SEL_EN
   assign ga_in = s_gain1x;
`else
   assign ga_in = '1;
`endif

   // Narrow samples are left-justified into the DAC's 12-bit field.
   function automatic logic [11:0] justify(input logic [DATA_W-1:0] s);
      return 12'(s) << (12 - DATA_W);
   endfunction

   assign s_ready    = !rst && (state == IDLE || state == DONE);
   assign accept     = s_valid && s_ready;
   assign period_end = tick && phase;
   assign gap_last   = (gap_cnt == GW'(CS_GAP - 1));
   assign ch_last    = (ch == CH_W'(N_CH - 1));
   assign nxt_ch     = ch + CH_W'(1);
   assign first_word = build_word(8'd0, justify(s_data[0 +: DATA_W]), ga_in[0]);
   assign next_word  = build_word(8'(nxt_ch), justify(frame_buf[nxt_ch*DATA_W +: DATA_W]),
                                  ga_buf[nxt_ch]);

   spi_dac_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
      .clk  (clk),
      .clr  (rst || accept),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         phase   <= 1'b0;
         bit_cnt <= '0;
         gap_cnt <= '0;
         ch      <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  state   <= SHIFT;
                  phase   <= 1'b0;
                  bit_cnt <= '0;
                  ch      <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               if (tick) phase <= ~phase;
               if (period_end) begin
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd15) begin
                     state   <= GAP;
                     gap_cnt <= '0;
                  end
               end
            end
            GAP: begin
               if (tick) phase <= ~phase;
               if (period_end) begin
                  if (!gap_last) begin
                     gap_cnt <= gap_cnt + GW'(1);
                  end else if (ch_last) begin
                     state <= LDAC;
                  end else begin
                     ch      <= nxt_ch;
                     bit_cnt <= '0;
                     state   <= SHIFT;
                  end
               end
            end
            LDAC: begin
               if (tick) phase <= ~phase;
               if (period_end) state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Frame data path carries no reset; sdi is gated by state so it stays low while idle.
   always_ff @(posedge clk) begin
      if (accept) begin
         frame_buf <= s_data;
         ga_buf    <= ga_in;
         sr        <= first_word;
      end else if (state == SHIFT && period_end) begin
         sr <= {sr[WORD_W-2:0], 1'b0};
      end else if (state == GAP && period_end && gap_last && !ch_last) begin
         sr <= next_word;
      end
   end

   assign sck        = (state == SHIFT) && phase;
   assign sdi        = (state == SHIFT) && sr[WORD_W-1];
   assign ldac_n     = (state != LDAC);
   assign busy       = (state == SHIFT) || (state == GAP) || (state == LDAC);
   assign frame_done = (state == DONE);

   always_comb begin
      cs_n = '1;
      for (int k = 0; k < N_CH/2; k++) begin
         if (state == SHIFT && (int'(ch) / 2) == k) cs_n[k] = 1'b0;
      end
   end

endmodule

// File: tb/tb_spi_dac_stream.sv
// Bench for spi_dac_stream: a 2-channel instance (CLK_DIV=2) and a 4-channel instance (CLK_DIV=1),
// with SPI words decoded from the pins and compared against an arithmetic word model.
module tb_spi_dac_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic        va, ra, scka, sdia, ldaca, busya, fda;
   logic [23:0] da;
   logic [0:0]  csa;
   logic        vb, rb, sckb, sdib, ldacb, busyb, fdb;
   logic [47:0] db;
   logic [1:0]  csb;
`ifdef SPI_DAC_GAIN_SEL_EN
   logic [1:0]  gaa;
   logic [3:0]  gab;
`endif

   spi_dac_stream #(.CLK_DIV(2), .N_CH(2), .DATA_W(12), .CS_GAP(2)) dut_a (
      .clk(clk), .rst(rst), .s_valid(va), .s_ready(ra), .s_data(da),
`ifdef SPI_DAC_GAIN_SEL_EN
      .s_gain1x(gaa),
`endif
      .sck(scka), .sdi(sdia), .cs_n(csa), .ldac_n(ldaca), .busy(busya), .frame_done(fda));

   spi_dac_stream #(.CLK_DIV(1), .N_CH(4), .DATA_W(12), .CS_GAP(2)) dut_b (
      .clk(clk), .rst(rst), .s_valid(vb), .s_ready(rb), .s_data(db),
`ifdef SPI_DAC_GAIN_SEL_EN
      .s_gain1x(gab),
`endif
      .sck(sckb), .sdi(sdib), .cs_n(csb), .ldac_n(ldacb), .busy(busyb), .frame_done(fdb));

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   // Pin-level SPI decoder, one slot per instance.
   typedef struct { int cs; int w; } word_t;
   word_t       qw0[$];
   word_t       qw1[$];
   int          nb[2], partial[2], ldacs[2], viol[2], accepts[2];
   logic [15:0] acc[2];
   logic        psck[2], pldac[2];
   logic [1:0]  pcs[2];

   task automatic mon(input int u, input logic sck, input logic sdi, input logic [1:0] cs,
                      input logic ldac, input logic v, input logic r);
      word_t e;
      int    lows;
      lows = 0;
      for (int k = 0; k < 2; k++) if (cs[k] == 1'b0) lows++;
      if (lows > 1 || (sck && lows == 0)) viol[u]++;
      if (sck && !psck[u]) begin
         acc[u] = {acc[u][14:0], sdi};
         nb[u]++;
      end
      for (int k = 0; k < 2; k++) begin
         if (pcs[u][k] && !cs[k]) begin
            nb[u]  = 0;
            acc[u] = '0;
         end
         if (!pcs[u][k] && cs[k]) begin
            if (nb[u] == 16) begin
               e.cs = k;
               e.w  = int'(acc[u]);
               if (u == 0) qw0.push_back(e);
               else        qw1.push_back(e);
            end else begin
               partial[u]++;
            end
         end
      end
      if (pldac[u] && !ldac) ldacs[u]++;
      if (v && r) accepts[u]++;
      psck[u]  = sck;
      pcs[u]   = cs;
      pldac[u] = ldac;
   endtask

   always @(negedge clk) begin
      mon(0, scka, sdia, {1'b1, csa}, ldaca, va, ra);
      mon(1, sckb, sdib, csb, ldacb, vb, rb);
   end

   // Word model: DAC select = channel parity, BUF=0, GA_n, SHDN_n=1, then the 12-bit sample.
   function automatic int model_word(input int i, input int sample, input int ga_n);
      return (i % 2) * 32768 + ga_n * 8192 + 4096 + sample;
   endfunction

   task automatic expect_word(input int u, input int cs, input int w, input string nm);
      word_t e;
      if ((u == 0) ? (qw0.size() == 0) : (qw1.size() == 0)) begin
         check({nm, "_present"}, 0, 1);
      end else begin
         e = (u == 0) ? qw0.pop_front() : qw1.pop_front();
         check({nm, "_cs"}, e.cs, cs);
         check(nm, e.w, w);
      end
   endtask

   task automatic expect_frame(input int u, input int n, input int smp[4], input int ga[4],
                               input string nm);
      for (int i = 0; i < n; i++)
         expect_word(u, i / 2, model_word(i, smp[i], ga[i]), $sformatf("%s_w%0d", nm, i));
   endtask

   function automatic logic [47:0] pack4(input int s[4]);
      return {12'(s[3]), 12'(s[2]), 12'(s[1]), 12'(s[0])};
   endfunction

   task automatic start(input int u, input logic [47:0] data);
      bit ok;
      ok = 0;
      @(posedge clk); #1;
      if (u == 0) begin va = 1'b1; da = data[23:0]; end
      else        begin vb = 1'b1; db = data;       end
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if ((u == 0) ? ra : rb) begin ok = 1; break; end
      end
      if (!ok) check("ready_timeout", 0, 1);
      @(posedge clk); #1;
      if (u == 0) va = 1'b0;
      else        vb = 1'b0;
   endtask

   // lat counts clocks from the accept cycle (clk 0) to the frame_done cycle.
   task automatic wait_done(input int u, output int lat);
      bit ok;
      ok  = 0;
      lat = 1;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (c == 0) check("busy_after_accept", int'((u == 0) ? busya : busyb), 1);
         if ((u == 0) ? fda : fdb) begin ok = 1; break; end
         lat++;
      end
      if (!ok) check("done_timeout", 0, 1);
   endtask

   typedef struct { int s0; int s1; int w0; int w1; } vec_t;
   vec_t tbl[4];
   int   ga_a[4] = '{1, 1, 1, 1};
   int   ga_b[4] = '{1, 1, 1, 1};

   initial begin
      int lat, l0, a0, p0, fdc, smp[4], bb[4][4];
      bit ok;
      for (int u = 0; u < 2; u++) begin
         nb[u] = 0; partial[u] = 0; ldacs[u] = 0; viol[u] = 0; accepts[u] = 0;
         acc[u] = '0; psck[u] = 1'b0; pcs[u] = 2'b11; pldac[u] = 1'b1;
      end
      tbl[0] = '{32'hABC, 32'h123, 32'h3ABC, 32'hB123};
      tbl[1] = '{32'h000, 32'h000, 32'h3000, 32'hB000};
      tbl[2] = '{32'hFFF, 32'hFFF, 32'h3FFF, 32'hBFFF};
      tbl[3] = '{32'h555, 32'h555, 32'h3555, 32'hB555};
      rst = 1'b1; va = 1'b0; vb = 1'b0; da = '0; db = '0;
`ifdef SPI_DAC_GAIN_SEL_EN
      gaa = '1; gab = '1;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", ra, 0);
      check("rst_sck", scka, 0);
      check("rst_sdi", sdia, 0);
      check("rst_cs", csa, 1);
      check("rst_ldac", ldaca, 1);
      check("rst_busy", busya, 0);
      check("rst_done", fda, 0);
      check("rst_cs_b", csb, 2'b11);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("idle_ready", ra, 1);

      // Table vectors on the 2-channel instance, with fixed frame latency.
      for (int t = 0; t < 4; t++) begin
         l0 = ldacs[0];
         start(0, {24'd0, 12'(tbl[t].s1), 12'(tbl[t].s0)});
         wait_done(0, lat);
         check($sformatf("tbl%0d_latency", t), lat, 149);
         check($sformatf("tbl%0d_ldac", t), ldacs[0] - l0, 1);
         expect_word(0, 0, tbl[t].w0, $sformatf("tbl%0d_w0", t));
         expect_word(0, 0, tbl[t].w1, $sformatf("tbl%0d_w1", t));
      end

      // s_valid held through a frame with changed data: only accepted again at frame_done.
      a0 = accepts[0]; l0 = ldacs[0];
      @(posedge clk); #1 va = 1'b1; da = {12'h123, 12'h456};
      ok = 0;
      for (int c = 0; c < 100; c++) begin @(negedge clk); if (ra) begin ok = 1; break; end end
      if (!ok) check("hold_ready_timeout", 0, 1);
      @(posedge clk); #1 da = {12'h789, 12'hA0B};
      wait_done(0, lat);
      check("hold_ready_at_done", ra, 1);
      @(posedge clk); #1 va = 1'b0;
      wait_done(0, lat);
      check("hold_accepts", accepts[0] - a0, 2);
      check("hold_ldacs", ldacs[0] - l0, 2);
      expect_frame(0, 2, '{32'h456, 32'h123, 0, 0}, ga_a, "hold_f0");
      expect_frame(0, 2, '{32'hA0B, 32'h789, 0, 0}, ga_a, "hold_f1");

      // Reset in the middle of channel 1's word.
      l0 = ldacs[0]; p0 = partial[0];
      start(0, {24'd0, 12'h321, 12'h654});
      repeat (100) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); @(negedge clk);
      check("midrst_cs", csa, 1);
      check("midrst_sck", scka, 0);
      check("midrst_sdi", sdia, 0);
      check("midrst_ldac", ldaca, 1);
      check("midrst_busy", busya, 0);
      check("midrst_ready", ra, 0);
      @(posedge clk); #1 rst = 1'b0;
      fdc = 0;
      for (int c = 0; c < 200; c++) begin @(negedge clk); if (fda) fdc++; end
      check("midrst_no_done", fdc, 0);
      check("midrst_no_ldac", ldacs[0] - l0, 0);
      check("midrst_partial", partial[0] - p0, 1);
      expect_word(0, 0, model_word(0, 32'h654, 1), "midrst_ch0");
      check("midrst_queue_empty", qw0.size(), 0);
      start(0, {24'd0, 12'h0F0, 12'h00F});
      wait_done(0, lat);
      expect_frame(0, 2, '{32'h00F, 32'h0F0, 0, 0}, ga_a, "after_rst");

`ifdef SPI_DAC_GAIN_SEL_EN
      gaa = 2'b01;
      ga_a[0] = 1; ga_a[1] = 0;
      start(0, {24'd0, 12'h555, 12'h555});
      wait_done(0, lat);
      expect_frame(0, 2, '{32'h555, 32'h555, 0, 0}, ga_a, "gain");
      gaa = '1;
      ga_a[1] = 1;
`endif

      // Random frames on the 2-channel instance against the model.
      for (int f = 0; f < 6; f++) begin
         for (int i = 0; i < 4; i++) smp[i] = (i < 2) ? int'($urandom_range(0, 4095)) : 0;
         start(0, pack4(smp));
         wait_done(0, lat);
         check($sformatf("rnd%0d_latency", f), lat, 149);
         expect_frame(0, 2, smp, ga_a, $sformatf("rnd%0d", f));
      end

      // 4-channel instance: boundary samples across two chip selects.
      l0 = ldacs[1];
      start(1, pack4('{32'h000, 32'hFFF, 32'h800, 32'h001}));
      wait_done(1, lat);
      check("n4_latency", lat, 147);
      check("n4_ldac", ldacs[1] - l0, 1);
      expect_word(1, 0, 32'h3000, "n4_w0");
      expect_word(1, 0, 32'hBFFF, "n4_w1");
      expect_word(1, 1, 32'h3800, "n4_w2");
      expect_word(1, 1, 32'hB001, "n4_w3");

      // Back-to-back frames with s_valid held high.
      l0 = ldacs[1]; a0 = accepts[1];
      for (int f = 0; f < 4; f++)
         for (int i = 0; i < 4; i++) bb[f][i] = int'($urandom_range(0, 4095));
      @(posedge clk); #1 vb = 1'b1; db = pack4(bb[0]);
      for (int f = 0; f < 4; f++) begin
         ok = 0;
         for (int c = 0; c < 500; c++) begin @(negedge clk); if (rb) begin ok = 1; break; end end
         if (!ok) check("b2b_ready_timeout", 0, 1);
         @(posedge clk); #1;
         if (f < 3) db = pack4(bb[f + 1]);
         else       vb = 1'b0;
      end
      wait_done(1, lat);
      check("b2b_latency", lat, 147);
      check("b2b_accepts", accepts[1] - a0, 4);
      check("b2b_ldacs", ldacs[1] - l0, 4);
      for (int f = 0; f < 4; f++) expect_frame(1, 4, bb[f], ga_b, $sformatf("b2b%0d", f));

      check("viol_a", viol[0], 0);
      check("viol_b", viol[1], 0);
      check("partial_b", partial[1], 0);
      check("partial_a", partial[0], 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
